// File: rtl/clz_skip_divider_pkg.sv
// clz_skip_divider_pkg: shared widths and the requester/divider operand bundle.
`default_nettype none

package clz_skip_divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;
  localparam int CLZ_WIDTH_DEFAULT = $clog2(DIV_WIDTH_DEFAULT);

  // Operand bundle for a later struct-based requester/divider hookup.
  typedef struct packed {
    logic [DIV_WIDTH_DEFAULT-1:0] dividend;
    logic [DIV_WIDTH_DEFAULT-1:0] divisor;
    logic [CLZ_WIDTH_DEFAULT-1:0] dividend_clz;
    logic [CLZ_WIDTH_DEFAULT-1:0] divisor_clz;
    logic                         divisor_is_zero;
  } div_operands_t;

endpackage

`default_nettype wire

// File: rtl/clz_skip_divider_if.sv
// clz_skip_divider_if: request/result bundle between requester (master) and divider (slave).
`default_nettype none

interface clz_skip_divider_if
  import clz_skip_divider_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
);

  localparam int CLZ_WIDTH = $clog2(DIV_WIDTH);

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic [CLZ_WIDTH-1:0] dividend_CLZ;
  logic [CLZ_WIDTH-1:0] divisor_CLZ;
  logic                 divisor_is_zero;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 done;
  logic                 busy;

  modport master (
    output start, dividend, divisor, dividend_CLZ, divisor_CLZ, divisor_is_zero,
    input  quotient, remainder, done, busy
  );

  modport slave (
    input  start, dividend, divisor, dividend_CLZ, divisor_CLZ, divisor_is_zero,
    output quotient, remainder, done, busy
  );

endinterface

`default_nettype wire

// File: rtl/clz_skip_divider.sv
// clz_skip_divider: restoring divider that skips leading-zero iterations using
// requester-supplied CLZ counts; K+1 iterations where K = divisor_CLZ - dividend_CLZ.
`default_nettype none

module clz_skip_divider
  import clz_skip_divider_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  clz_skip_divider_if.slave bus
);

  localparam int CLZ_WIDTH = $clog2(DIV_WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state,   state_nxt;
  logic [DIV_WIDTH-1:0] quo,     quo_nxt;
  logic [DIV_WIDTH-1:0] rem,     rem_nxt;
  logic [DIV_WIDTH-1:0] aln,     aln_nxt;
  logic [CLZ_WIDTH-1:0] cnt,     cnt_nxt;
  logic                 done_r,  done_nxt;
  logic [CLZ_WIDTH-1:0] shift_k;
  logic                 fits;

  assign shift_k = bus.divisor_CLZ - bus.dividend_CLZ;
  assign fits    = (rem >= aln);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      quo    <= '0;
      rem    <= '0;
      aln    <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      quo    <= quo_nxt;
      rem    <= rem_nxt;
      aln    <= aln_nxt;
      cnt    <= cnt_nxt;
      done_r <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    quo_nxt   = quo;
    rem_nxt   = rem;
    aln_nxt   = aln;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;

    if (bus.start) begin
      // A start always wins, including mid-RUN: the old operation is dropped.
      rem_nxt = bus.dividend;
      quo_nxt = '0;
      if (bus.divisor_is_zero) begin
        quo_nxt   = '1;
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else if (bus.divisor_CLZ < bus.dividend_CLZ) begin
        // Fewer leading zeros means the divisor is strictly larger: quotient is 0.
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        aln_nxt   = bus.divisor << shift_k;
        cnt_nxt   = shift_k;
        state_nxt = RUN;
      end
    end else if (state == RUN) begin
      rem_nxt = fits ? (rem - aln) : rem;
      quo_nxt = {quo[DIV_WIDTH-2:0], fits};
      aln_nxt = aln >> 1;
      if (cnt == '0) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
    end
  end

  assign bus.quotient  = quo;
  assign bus.remainder = rem;
  assign bus.done      = done_r;
  assign bus.busy      = (state == RUN);

endmodule

`default_nettype wire
